// File: rtl/move_executor.sv
// move_executor: applies one chess move per request, scanning both sides piece by piece for collisions and captures.
module move_executor #(
  parameter logic WHITE = 1'b1,
  parameter logic BLACK = 1'b0,
  parameter int NUM_PIECES = 16
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      pl,
  input  logic [3:0]                piece_to_move,
  input  logic [5:0]                move_in,
  output logic [6*NUM_PIECES-1:0]   location_vectors_w,
  output logic [6*NUM_PIECES-1:0]   location_vectors_b,
  output logic [NUM_PIECES-1:0]     alive_vectors_w,
  output logic [NUM_PIECES-1:0]     alive_vectors_b,
  output logic                      busy,
  output logic                      done,
  output logic                      captured,
  output logic [3:0]                captured_piece,
  output logic                      illegal,
  output logic                      game_over
);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DONE} state_t;
  localparam logic [3:0] LAST = 4'(NUM_PIECES - 1);
  // Back-rank files for indices 7..0 (R1 N2... packed with index 0 in the low bits)
  localparam logic [47:0] BACK_FILES = {6'd0, 6'd7, 6'd1, 6'd6, 6'd2, 6'd5, 6'd3, 6'd4};
  function automatic logic [6*NUM_PIECES-1:0] init_loc(input logic [5:0] back, input logic [5:0] pawn);
    logic [6*NUM_PIECES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PIECES; i++)
      v[6*i +: 6] = i < 8 ? back + BACK_FILES[6*i +: 6] : pawn + 6'(NUM_PIECES - 1 - i);
    return v;
  endfunction
  state_t state, nxt;
  logic pl_r, ill, hit, ok, accept;
  logic [3:0] pc_r, idx, tgt;
  logic [5:0] mv_r;
  logic [6*NUM_PIECES-1:0] own_loc, opp_loc;
  logic [NUM_PIECES-1:0] own_alive, opp_alive;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    accept = state == IDLE && start && !game_over;
    nxt = state == IDLE ? (accept ? SCAN : IDLE) :
          state == SCAN ? (idx == LAST ? COMMIT : SCAN) :
          state == COMMIT ? DONE : IDLE;
    own_loc = pl_r == WHITE ? location_vectors_w : location_vectors_b;
    opp_loc = pl_r == WHITE ? location_vectors_b : location_vectors_w;
    own_alive = pl_r == WHITE ? alive_vectors_w : alive_vectors_b;
    opp_alive = pl_r == WHITE ? alive_vectors_b : alive_vectors_w;
    ok = !ill && own_alive[pc_r];
  end
  always_ff @(posedge clk)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk) begin
    if (RST) begin
      pl_r <= WHITE;
      pc_r <= '0;
      mv_r <= '0;
      idx <= '0;
      ill <= 1'b0;
      hit <= 1'b0;
      tgt <= '0;
      captured <= 1'b0;
      captured_piece <= '0;
      illegal <= 1'b0;
      game_over <= 1'b0;
      alive_vectors_w <= '1;
      alive_vectors_b <= '1;
      location_vectors_w <= init_loc(6'd0, 6'd8);
      location_vectors_b <= init_loc(6'd56, 6'd48);
    end else begin
      if (accept) begin
        pl_r <= pl;
        pc_r <= piece_to_move;
        mv_r <= move_in;
        idx <= '0;
        ill <= 1'b0;
        hit <= 1'b0;
        tgt <= '0;
        captured <= 1'b0;
        captured_piece <= '0;
        illegal <= 1'b0;
      end
      if (state == SCAN) begin
        idx <= idx + 4'd1;
        // Any alive own piece on the destination, the mover included, blocks the move
        if (own_alive[idx] && own_loc[6*idx +: 6] == mv_r) ill <= 1'b1;
        if (opp_alive[idx] && opp_loc[6*idx +: 6] == mv_r && !hit) begin
          hit <= 1'b1;
          tgt <= idx;
        end
      end
      if (state == COMMIT) begin
        illegal <= !ok;
        captured <= ok && hit;
        captured_piece <= ok && hit ? tgt : 4'd0;
        if (ok && hit && tgt == 4'd0) game_over <= 1'b1;
        if (ok && pl_r == WHITE) begin
          location_vectors_w[6*pc_r +: 6] <= mv_r;
          if (hit) alive_vectors_b[tgt] <= 1'b0;
        end
        if (ok && pl_r != WHITE) begin
          location_vectors_b[6*pc_r +: 6] <= mv_r;
          if (hit) alive_vectors_w[tgt] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_move_executor.sv
// tb_move_executor: scoreboard bench; a board model predicts each request's result, compared when done pulses.
module tb_move_executor;
  logic clk = 0, RST = 1, start = 0, pl = 1;
  logic [3:0] piece_to_move = 0;
  logic [5:0] move_in = 0;
  logic [95:0] location_vectors_w, location_vectors_b;
  logic [15:0] alive_vectors_w, alive_vectors_b;
  logic busy, done, captured, illegal, game_over;
  logic [3:0] captured_piece;
  int tests = 0, fails = 0;
  int wsq [16] = '{4, 3, 5, 2, 6, 1, 7, 0, 15, 14, 13, 12, 11, 10, 9, 8};
  int bsq [16] = '{60, 59, 61, 58, 62, 57, 63, 56, 55, 54, 53, 52, 51, 50, 49, 48};
  typedef struct {
    logic [95:0] lw, lb;
    logic [15:0] aw, ab;
    logic cap, ill, go;
    logic [3:0] cp;
  } exp_t;
  exp_t q [$];
  logic [95:0] m_lw, m_lb;
  logic [15:0] m_aw, m_ab;
  logic m_go;

  move_executor dut (
    .clk(clk), .RST(RST), .start(start), .pl(pl), .piece_to_move(piece_to_move), .move_in(move_in),
    .location_vectors_w(location_vectors_w), .location_vectors_b(location_vectors_b),
    .alive_vectors_w(alive_vectors_w), .alive_vectors_b(alive_vectors_b),
    .busy(busy), .done(done), .captured(captured), .captured_piece(captured_piece),
    .illegal(illegal), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_lw[6*i +: 6] = wsq[i][5:0];
      m_lb[6*i +: 6] = bsq[i][5:0];
    end
    m_aw = '1;
    m_ab = '1;
    m_go = 0;
    q.delete();
  endtask

  task automatic predict(input logic p, input logic [3:0] pc, input logic [5:0] mv);
    exp_t e;
    logic [95:0] ol, xl;
    logic [15:0] oa, xa;
    logic bad, hit;
    logic [3:0] t;
    ol = p ? m_lw : m_lb;
    xl = p ? m_lb : m_lw;
    oa = p ? m_aw : m_ab;
    xa = p ? m_ab : m_aw;
    bad = !oa[pc];
    hit = 0;
    t = 0;
    for (int i = 15; i >= 0; i--) begin
      if (oa[i] && ol[6*i +: 6] == mv) bad = 1;
      if (xa[i] && xl[6*i +: 6] == mv) begin
        hit = 1;
        t = i[3:0];
      end
    end
    if (!bad) begin
      ol[6*pc +: 6] = mv;
      if (hit) xa[t] = 0;
    end
    if (p) begin m_lw = ol; m_lb = xl; m_aw = oa; m_ab = xa; end
    else begin m_lb = ol; m_lw = xl; m_ab = oa; m_aw = xa; end
    if (!bad && hit && t == 0) m_go = 1;
    e.lw = m_lw; e.lb = m_lb; e.aw = m_aw; e.ab = m_ab;
    e.cap = !bad && hit;
    e.cp = (!bad && hit) ? t : 4'd0;
    e.ill = bad;
    e.go = m_go;
    q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = q.pop_front();
    check({tag, "_loc_w"}, location_vectors_w, e.lw);
    check({tag, "_loc_b"}, location_vectors_b, e.lb);
    check({tag, "_alive_w"}, alive_vectors_w, e.aw);
    check({tag, "_alive_b"}, alive_vectors_b, e.ab);
    check({tag, "_captured"}, captured, e.cap);
    check({tag, "_cap_piece"}, captured_piece, e.cp);
    check({tag, "_illegal"}, illegal, e.ill);
    check({tag, "_game_over"}, game_over, e.go);
  endtask

  task automatic do_reset();
    RST = 1;
    repeat (2) @(posedge clk);
    #1 RST = 0;
    model_reset();
  endtask

  // One request: inputs are scrambled right after acceptance to prove they were latched
  task automatic do_move(input string tag, input logic p, input logic [3:0] pc, input logic [5:0] mv);
    int n;
    predict(p, pc, mv);
    @(negedge clk);
    pl = p; piece_to_move = pc; move_in = mv; start = 1;
    @(posedge clk);
    #1 start = 0;
    pl = ~p; piece_to_move = pc ^ 4'hF; move_in = mv ^ 6'h2A;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, n, 17);
    compare_out(tag);
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int n, dn, seen;
    int dt [3];
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {captured, captured_piece, illegal, game_over}, 0);
    check("rst_alive", {alive_vectors_w, alive_vectors_b}, 32'hFFFF_FFFF);
    check("rst_loc_w", location_vectors_w, m_lw);
    check("rst_loc_b", location_vectors_b, m_lb);

    do_move("w_p5", 1, 4'd11, 6'd28);
    check("w_p5_slice", location_vectors_w[66 +: 6], 28);
    do_move("b_p4_cap", 0, 4'd12, 6'd28);
    check("b_p4_kill", alive_vectors_w[11], 0);
    do_move("w_r1_own", 1, 4'd7, 6'd1);
    do_move("w_n1_same", 1, 4'd5, 6'd1);
    do_move("w_dead", 1, 4'd11, 6'd40);

    predict(1, 4'd5, 6'd18);
    predict(1, 4'd5, 6'd18);
    predict(1, 4'd5, 6'd18);
    @(negedge clk);
    pl = 1; piece_to_move = 4'd5; move_in = 6'd18; start = 1;
    n = 0; dn = 0;
    while (dn < 3 && n < 80) begin
      @(posedge clk);
      #1 n++;
      if (done) begin
        dt[dn] = n;
        compare_out("hold");
        dn++;
        if (dn == 3) start = 0;
      end
    end
    start = 0;
    check("hold_count", dn, 3);
    check("hold_first", dt[0], 18);
    check("hold_gap1", dt[1] - dt[0], 19);
    check("hold_gap2", dt[2] - dt[1], 19);
    @(posedge clk);
    #1 check("hold_idle", {busy, done}, 2'b00);

    @(negedge clk);
    pl = 0; piece_to_move = 4'd1; move_in = 6'd4; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(posedge clk);
    #1 RST = 1;
    @(posedge clk);
    #1 RST = 0;
    model_reset();
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    check("abort_quiet", seen, 0);
    check("abort_loc_w", location_vectors_w, m_lw);
    check("abort_loc_b", location_vectors_b, m_lb);
    check("abort_alive", {alive_vectors_w, alive_vectors_b}, 32'hFFFF_FFFF);
    do_move("after_abort", 1, 4'd12, 6'd27);

    do_move("king_cap", 0, 4'd1, 6'd4);
    check("king_alive", alive_vectors_w[0], 0);
    check("king_go", game_over, 1);
    @(negedge clk);
    pl = 1; piece_to_move = 4'd8; move_in = 6'd23; start = 1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1;
    end
    start = 0;
    check("go_ignore", seen, 0);
    check("go_board", location_vectors_w, m_lw);
    check("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
